// File: rtl/seq_detect_ctrl_if.sv
// Word-in / result-out handshake bundle for the "001" scan controller.
interface seq_detect_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mask;
  logic [3:0] out_count;
  logic [3:0] out_first;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mask, out_count, out_first
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mask, out_count, out_first
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serialises an 8-bit word MSB first into an external "001" Moore detector,
// collects which bit positions produced a detection, and reports a mask,
// a popcount, the first hit index and a saturating running total.
module seq_detect_ctrl (
  input  logic               clk,
  input  logic               reset,
  seq_detect_ctrl_if.slave   bus,
  output logic               det_inp,
  output logic               det_clr,
  input  logic               det_det,
  output logic [15:0]        total_count,
  input  logic               stat_clr
);
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  word_q;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  first_q, first_d;
  logic [15:0] total_q;
  logic        in_ready_q, out_valid_q;
  logic        accept;
  logic        samp;
  logic [2:0]  samp_idx;
  logic [16:0] sum;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mask  = mask_q;
  assign bus.out_count = cnt_q;
  assign bus.out_first = first_q;
  assign total_count   = total_q;

  assign accept = (state_q == IDLE) && bus.in_valid && in_ready_q;

  // The detector output lags det_inp by two edges, so the hit for bit i is
  // seen while in SHIFT with idx i+1; bit 7 lands during DRAIN.
  assign samp     = ((state_q == SHIFT) && (idx_q != 3'd0)) || (state_q == DRAIN);
  assign samp_idx = (state_q == DRAIN) ? 3'd7 : idx_q - 3'd1;

  // Next-state and bit index sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:  if (accept) state_d = CLEAR;
      CLEAR: begin
        state_d = SHIFT;
        idx_d   = 3'd0;
      end
      SHIFT: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result accumulation: cleared on accept, one bit per detector sample.
  always_comb begin
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (accept) begin
      mask_d  = 8'h00;
      cnt_d   = 4'd0;
      first_d = 4'hF;
    end else if (samp && det_det) begin
      mask_d[3'd7 - samp_idx] = 1'b1;
      cnt_d = cnt_q + 4'd1;
      if (first_q == 4'hF) first_d = {1'b0, samp_idx};
    end
  end

  assign sum = {1'b0, total_q} + {13'd0, cnt_d};

  // State, word latch, result registers and registered detector/handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      word_q      <= 8'h00;
      mask_q      <= 8'h00;
      cnt_q       <= 4'd0;
      first_q     <= 4'hF;
      det_clr     <= 1'b1;
      det_inp     <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      if (accept) word_q <= bus.in_data;
      det_clr     <= (state_d == CLEAR);
      det_inp     <= (state_d == SHIFT) ? word_q[3'd7 - idx_d] : 1'b1;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Running total: bumps on DRAIN->DONE, saturates, and a clear always wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_q <= 16'h0000;
    end else if (stat_clr) begin
      total_q <= 16'h0000;
    end else if (state_q == DRAIN) begin
      total_q <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end
endmodule
